// File: rtl/fwd_tracker.sv
// Forwarding and load-use hazard tracker: a DEPTH-deep shift register of in-flight
// producers feeding a youngest-wins compare tree, plus a saturating stall counter.
module fwd_tracker #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      freeze_i,
  input  logic [ADDR_W-1:0]         ex_rd_i,
  input  logic                      ex_regwrite_i,
  input  logic                      ex_memread_i,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_rs_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      hazard_stall_o,
  output logic                      fwd_load_err_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  // Entry k-1 of each vector is stage k (stage 1 = MEM).
  logic [DEPTH-1:0]        valid_r;
  logic [DEPTH*ADDR_W-1:0] rd_r;
  logic [DEPTH-1:0]        load_r;
  logic [CNT_W-1:0]        stall_cnt_r;

  logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
  logic                     id_hit_s;
  logic                     hazard_raw_s;
  logic                     sel1_hit_s;
  logic                     load_err_raw_s;

  // Producer shift register and stall counter; reset wins over freeze.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r     <= '0;
      rd_r        <= '0;
      load_r      <= '0;
      stall_cnt_r <= '0;
    end else if (!freeze_i) begin
      valid_r[0]          <= ex_regwrite_i && (ex_rd_i != '0);
      rd_r[ADDR_W-1:0]    <= ex_rd_i;
      load_r[0]           <= ex_memread_i;
      for (int k = 1; k < DEPTH; k++) begin
        valid_r[k]                 <= valid_r[k-1];
        rd_r[k*ADDR_W +: ADDR_W]   <= rd_r[(k-1)*ADDR_W +: ADDR_W];
        load_r[k]                  <= load_r[k-1];
      end
      if (hazard_raw_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
    end
  end

  // Forward select: scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_sel_s = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        fwd_sel_s[j*SEL_W +: SEL_W] =
          (valid_r[k-1] &&
           (rd_r[(k-1)*ADDR_W +: ADDR_W] == ex_rs_i[j*ADDR_W +: ADDR_W]) &&
           (ex_rs_i[j*ADDR_W +: ADDR_W] != '0)) ? SEL_W'(k) : fwd_sel_s[j*SEL_W +: SEL_W];
      end
    end
  end

  // Load-use detection against ID sources and the stage-1 load checker.
  always_comb begin
    id_hit_s   = 1'b0;
    sel1_hit_s = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      id_hit_s   = id_hit_s | (id_rs_i[j*ADDR_W +: ADDR_W] == ex_rd_i);
      sel1_hit_s = sel1_hit_s | (fwd_sel_s[j*SEL_W +: SEL_W] == SEL_W'(1));
    end
    hazard_raw_s   = ex_memread_i && ex_regwrite_i && (ex_rd_i != '0) && id_hit_s;
    load_err_raw_s = sel1_hit_s && load_r[0];
  end

  assign fwd_sel_o      = rst_i ? '0 : fwd_sel_s;
  assign hazard_stall_o = rst_i ? 1'b0 : hazard_raw_s;
  assign fwd_load_err_o = rst_i ? 1'b0 : load_err_raw_s;
  assign stall_cnt_o    = stall_cnt_r;

endmodule

// File: tb/tb_fwd_tracker.sv
// Directed bench for fwd_tracker: default instance, a DEPTH=3/NUM_SRC=3 instance and
// a CNT_W=2 instance sharing the default instance's stimulus.
module tb_fwd_tracker;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic [4:0]  ex_rd;
  logic        ex_rw;
  logic        ex_mr;
  logic [9:0]  ex_rs;
  logic [9:0]  id_rs;
  logic [3:0]  sel_a;
  logic        haz_a;
  logic        err_a;
  logic [15:0] cnt_a;

  logic [4:0]  b_ex_rd;
  logic        b_ex_rw;
  logic        b_ex_mr;
  logic [14:0] b_ex_rs;
  logic [14:0] b_id_rs;
  logic [5:0]  sel_b;
  logic        haz_b;
  logic        err_b;
  logic [15:0] cnt_b;

  logic [3:0]  sel_c;
  logic        haz_c;
  logic        err_c;
  logic [1:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  fwd_tracker dut_a (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr),
    .ex_rs_i(ex_rs), .id_rs_i(id_rs),
    .fwd_sel_o(sel_a), .hazard_stall_o(haz_a), .fwd_load_err_o(err_a), .stall_cnt_o(cnt_a)
  );

  fwd_tracker #(.NUM_SRC(3), .DEPTH(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze),
    .ex_rd_i(b_ex_rd), .ex_regwrite_i(b_ex_rw), .ex_memread_i(b_ex_mr),
    .ex_rs_i(b_ex_rs), .id_rs_i(b_id_rs),
    .fwd_sel_o(sel_b), .hazard_stall_o(haz_b), .fwd_load_err_o(err_b), .stall_cnt_o(cnt_b)
  );

  fwd_tracker #(.CNT_W(2)) dut_c (
    .clk_i(clk), .rst_i(rst), .freeze_i(freeze),
    .ex_rd_i(ex_rd), .ex_regwrite_i(ex_rw), .ex_memread_i(ex_mr),
    .ex_rs_i(ex_rs), .id_rs_i(id_rs),
    .fwd_sel_o(sel_c), .hazard_stall_o(haz_c), .fwd_load_err_o(err_c), .stall_cnt_o(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] rd, input logic rw, input logic mr,
                        input logic [4:0] rs1, input logic [4:0] rs0);
    ex_rd = rd; ex_rw = rw; ex_mr = mr; ex_rs = {rs1, rs0};
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0;
    set_ex(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
    id_rs = {5'd0, 5'd3};
    b_ex_rd = 5'd0; b_ex_rw = 1'b0; b_ex_mr = 1'b0; b_ex_rs = 15'd0; b_id_rs = 15'd0;
    #1;
    tick();
    // Reset: outputs forced low even with a live load-use on the inputs
    chk("rst_sel", {28'd0, sel_a}, 32'd0);
    chk("rst_haz", {31'd0, haz_a}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    chk("rst_sel_b", {26'd0, sel_b}, 32'd0);
    rst = 1'b0;
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    id_rs = 10'd0;
    tick();

    // 1. back-to-back chain on x5
    set_ex(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd5);
    #1 chk("chain_sel1", {28'd0, sel_a}, 32'h1);
    tick();
    set_ex(5'd0, 1'b0, 1'b0, 5'd5, 5'd0);
    #1 chk("chain_sel2", {28'd0, sel_a}, 32'h8);
    tick();
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd5);
    #1 chk("chain_sel0", {28'd0, sel_a}, 32'h0);
    tick();

    // 2. priority: x7 written twice, youngest wins on both sources
    set_ex(5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    set_ex(5'd0, 1'b0, 1'b0, 5'd7, 5'd7);
    #1 chk("prio_sel", {28'd0, sel_a}, 32'h5);
    chk("prio_err", {31'd0, err_a}, 32'd0);
    tick();

    // 3. x0 never recorded
    set_ex(5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    #1 chk("x0_sel", {28'd0, sel_a}, 32'h0);
    tick();

    // 4. load-use: non-matching ID sources leave the counter alone
    set_ex(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
    id_rs = {5'd6, 5'd4};
    #1 chk("lu_nohaz", {31'd0, haz_a}, 32'd0);
    tick();
    chk("lu_cnt0", {16'd0, cnt_a}, 32'd0);
    id_rs = {5'd3, 5'd0};
    #1 chk("lu_haz", {31'd0, haz_a}, 32'd1);
    tick();
    chk("lu_cnt1", {16'd0, cnt_a}, 32'd1);
    chk("lu_cnt1_c", {30'd0, cnt_c}, 32'd1);
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd3);
    id_rs = 10'd0;
    #1 chk("lu_err", {31'd0, err_a}, 32'd1);
    chk("lu_err_sel", {28'd0, sel_a}, 32'h1);
    chk("lu_haz_off", {31'd0, haz_a}, 32'd0);
    tick();

    // 5. freeze holds x9 at stage 1; a load-use during freeze is not counted
    set_ex(5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    freeze = 1'b1;
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd9);
    #1 chk("frz_sel_a", {28'd0, sel_a}, 32'h1);
    tick();
    set_ex(5'd2, 1'b1, 1'b1, 5'd0, 5'd9);
    id_rs = {5'd0, 5'd2};
    #1 chk("frz_sel_b", {28'd0, sel_a}, 32'h1);
    chk("frz_haz", {31'd0, haz_a}, 32'd1);
    tick();
    chk("frz_cnt", {16'd0, cnt_a}, 32'd1);
    set_ex(5'd0, 1'b0, 1'b0, 5'd0, 5'd9);
    id_rs = 10'd0;
    #1 chk("frz_sel_c", {28'd0, sel_a}, 32'h1);
    chk("frz_err", {31'd0, err_a}, 32'd0);
    tick();
    freeze = 1'b0;
    #1 chk("frz_rel_sel1", {28'd0, sel_a}, 32'h1);
    tick();
    chk("frz_rel_sel2", {28'd0, sel_a}, 32'h1 << 1);

    // 6a. reset with freeze high discards in-flight producers
    set_ex(5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
    tick();
    set_ex(5'd4, 1'b1, 1'b0, 5'd0, 5'd4);
    #1 chk("fill_sel", {28'd0, sel_a}, 32'h1);
    tick();
    rst = 1'b1; freeze = 1'b1;
    #1 chk("rst2_forced", {28'd0, sel_a}, 32'h0);
    tick();
    rst = 1'b0; freeze = 1'b0;
    set_ex(5'd0, 1'b0, 1'b0, 5'd4, 5'd4);
    #1 chk("rst2_sel", {28'd0, sel_a}, 32'h0);
    chk("rst2_cnt", {16'd0, cnt_a}, 32'd0);
    chk("rst2_cnt_c", {30'd0, cnt_c}, 32'd0);
    tick();

    // 6b. DEPTH=3, NUM_SRC=3: producer x11 walks sel 1, 2, 3, 0 on sources 1 and 2
    b_ex_rd = 5'd11; b_ex_rw = 1'b1;
    tick();
    b_ex_rd = 5'd0; b_ex_rw = 1'b0; b_ex_rs = {5'd11, 5'd11, 5'd0};
    #1 chk("b_sel1", {26'd0, sel_b}, 32'h14);
    tick();
    chk("b_sel2", {26'd0, sel_b}, 32'h28);
    tick();
    chk("b_sel3", {26'd0, sel_b}, 32'h3c);
    tick();
    chk("b_sel0", {26'd0, sel_b}, 32'h0);
    b_ex_rd = 5'd12; b_ex_rw = 1'b1; b_ex_mr = 1'b1; b_id_rs = {5'd12, 5'd0, 5'd0};
    #1 chk("b_haz", {31'd0, haz_b}, 32'd1);
    tick();
    chk("b_cnt", {16'd0, cnt_b}, 32'd1);
    b_ex_rd = 5'd0; b_ex_rw = 1'b0; b_ex_mr = 1'b0; b_id_rs = 15'd0;
    b_ex_rs = {5'd0, 5'd0, 5'd12};
    #1 chk("b_err", {31'd0, err_b}, 32'd1);

    // 6c. CNT_W=2 saturates at 3 while the 16-bit counter keeps counting
    set_ex(5'd8, 1'b1, 1'b1, 5'd0, 5'd0);
    id_rs = {5'd8, 5'd8};
    tick();
    tick();
    chk("sat_cnt2", {30'd0, cnt_c}, 32'd2);
    tick();
    chk("sat_cnt3", {30'd0, cnt_c}, 32'd3);
    tick();
    tick();
    chk("sat_hold", {30'd0, cnt_c}, 32'd3);
    chk("sat_wide", {16'd0, cnt_a}, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_tracker.md
Name: fwd_tracker

Overview:
- Parametrised forwarding and hazard unit for the RISC-V pipeline.
- Owns an internal shift register of in-flight producers (rd, regwrite, memread) from the EX stage down DEPTH stages.
- Returns a per-source forward select for NUM_SRC operands of the EX instruction.
- Also raises load-use stall, flags illegal load forwarding, and keeps a saturating stall counter.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, source operands per instruction
DEPTH, 2, forwarding stages after EX (1=MEM, 2=WB, ...)
SEL_W, 2, select width; must satisfy 2**SEL_W > DEPTH
CNT_W, 16, stall counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
freeze_i  in  1  global pipeline freeze; tracker holds
ex_rd_i  in  ADDR_W  destination of instruction in EX
ex_regwrite_i  in  1  EX instruction writes rd
ex_memread_i  in  1  EX instruction is a load
ex_rs_i  in  NUM_SRC*ADDR_W  EX sources; source j in bits [j*ADDR_W +: ADDR_W]
id_rs_i  in  NUM_SRC*ADDR_W  ID sources, same packing
fwd_sel_o  out  NUM_SRC*SEL_W  per-source select; 0 = register file, k = stage k
hazard_stall_o  out  1  load-use stall request to IF/ID
fwd_load_err_o  out  1  a source selects a stage-1 load
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Tracker state: stage[1..DEPTH]. Each entry holds {valid, rd, is_load}.
- Capture rule: on each rising edge with rst_i=0 and freeze_i=0:
  - stage[1] <= {ex_regwrite_i && ex_rd_i!=0, ex_rd_i, ex_memread_i}
  - stage[k] <= stage[k-1] for k=2..DEPTH.
  - Writes to x0 are never recorded valid.
- freeze_i=1: all stages hold their values.
- Forward select, combinational from tracker and ex_rs_i:
  - fwd_sel[j] = smallest k with stage[k].valid && stage[k].rd == ex_rs[j] && ex_rs[j] != 0; otherwise 0.
  - The youngest producer always wins.
  - With DEPTH=2 this reproduces the classic MEM-over-WB priority; MEM maps to 1, WB to 2.
- Latency: a producer in EX at cycle t is visible as sel=1 in cycle t+1 and sel=k in cycle t+k, provided there is no freeze.
- hazard_stall_o (combinational):
  - Asserts when ex_memread_i && ex_regwrite_i && ex_rd_i != 0 && ex_rd_i matches any id_rs[j].
  - Independent of freeze_i.
- fwd_load_err_o (combinational): asserts when any fwd_sel[j]==1 and stage[1].is_load. This is a checker output; correct stalling keeps it 0.
- stall_cnt_o:
  - Increments by 1 on an edge where hazard_stall_o=1 and freeze_i=0.
  - Saturates at all-ones; no wrap.
- Reset: on an edge with rst_i=1, all stages are invalidated (valid=0, rd=0, is_load=0) and stall_cnt_o=0.
  - While rst_i=1, fwd_sel_o, hazard_stall_o and fwd_load_err_o are forced to 0.
  - Reset overrides freeze_i.
  - Reset mid-operation discards all in-flight producers.
- Simultaneous events: freeze_i together with hazard_stall_o gives stall asserted but no count. A stage matching both sources drives both selects identically.
- Pure shift register plus compare tree. No other state.

Test Plan:
1. Back-to-back chain, DEPTH=2. Cycle 0: EX add x5 (regwrite=1). Cycle 1: EX rs1=5 -> fwd_sel[0]=1. Cycle 2: EX rs2=5 -> fwd_sel[1]=2. Cycle 3: rs1=5 -> sel 0.
2. Priority. x7 is written by EX in cycles 0 and 1. Cycle 2: rs1=7, rs2=7 -> both sel=1, never 2.
3. x0 suppression. EX rd=0, regwrite=1. Next cycle rs1=0 -> sel 0. Stage[1].valid=0.
4. Load-use. ex_memread=1, regwrite=1, rd=3, id_rs1=3 -> hazard_stall_o=1 and stall_cnt_o goes 0->1 next cycle. Same with id_rs=4/6 -> hazard_stall_o=0 and the count is unchanged. Forcing EX rs1=3 one cycle after the load -> fwd_load_err_o=1.
5. Freeze. Load tracker with x9 at stage 1, then freeze_i=1 for 3 cycles -> rs1=9 stays sel=1 throughout. Drive a load-use during the freeze -> stall asserted, counter unchanged. Release freeze -> sel=2 next cycle.
6. Reset and parameter sweep. Fill the tracker, then pulse rst_i for 1 cycle with freeze_i=1 -> all selects 0 and counter 0. Repeat with DEPTH=3, NUM_SRC=3 -> a producer walks sel 1, 2, 3, 0. Preload the counter near saturation with CNT_W=2 -> it holds at 3.
